// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_AW       = 8;
    localparam int DEF_DW       = 8;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the port that did not own last wins.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       valid
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ~last_owner : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core / host loader) with lock and hold limit.
// Define ARB_STATS_EN to add saturating per-port grant counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1
`endif
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    arb_state_e    state, nxt;
    logic          last_owner;
    logic [HW-1:0] hold_cnt;
    logic          cur, cur_req, cur_lock, pick_last, pick_winner, pick_valid;

    assign gnt0 = (state == OWN0) & req0;
    assign gnt1 = (state == OWN1) & req1;

    assign cur      = (state == OWN1);
    assign cur_req  = cur ? req1 : req0;
    assign cur_lock = cur ? lock1 : lock0;

    // While owned, round-robin against the current owner gives "other first, else same".
    assign pick_last = (state == IDLE) ? last_owner : cur;

    rr_pick u_pick (
        .req        ({req1, req0}),
        .last_owner (pick_last),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        nxt = IDLE;
        if (state != IDLE && cur_lock && cur_req && hold_cnt < HOLD_LIM)
            nxt = state;
        else if (pick_valid)
            nxt = pick_winner ? OWN1 : OWN0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state <= nxt;
            if (nxt != IDLE)
                last_owner <= (nxt == OWN1);
            if (state != IDLE && nxt == state)
                hold_cnt <= (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_dat_in = '0;
        case (state)
            OWN0: begin
                mem_addr   = addr0;
                mem_dat_in = wdata0;
            end
            OWN1: begin
                mem_addr   = addr1;
                mem_dat_in = wdata1;
            end
            default: ;
        endcase
    end

    assign mem_wr_en = (gnt0 & we0) | (gnt1 & we1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 & ~we0)
                rdata0 <= mem_dat_out;
            if (gnt1 & ~we1)
                rdata1 <= mem_dat_out;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0)
                gnt_cnt0 <= sat_inc16(gnt_cnt0);
            if (gnt1)
                gnt_cnt1 <= sat_inc16(gnt_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a simple async-read memory model.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1, mem_wr_en;
    logic [7:0] rdata0, rdata1, mem_addr, mem_dat_in, mem_dat_out;
`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
        .mem_dat_out(mem_dat_out)
`ifdef ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    // Memory preloads mem[i] = i ^ 0x3C on the first clock, then follows the DUT's writes.
    logic [7:0] mem [256];
    logic       mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
            mem_init <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_dat_in;
        end
    end
    assign mem_dat_out = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    always @(negedge clk) if (rst_n === 1'b1) chk("mutex", {31'd0, gnt0 & gnt1}, 0);

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_rv0"}, rvalid0, 0);
        chk({tag, "_rv1"}, rvalid1, 0);
        chk({tag, "_wen"}, mem_wr_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_din"}, mem_dat_in, 0);
        chk({tag, "_rd0"}, rdata0, 0);
        chk({tag, "_rd1"}, rdata1, 0);
`ifdef ARB_STATS_EN
        chk({tag, "_cnt0"}, gnt_cnt0, 0);
        chk({tag, "_cnt1"}, gnt_cnt1, 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        {req0, we0, lock0, req1, we1, lock1} = '0;
        {addr0, wdata0, addr1, wdata1} = '0;
        step(); step();
        smp(); chk_quiet("rst");
        step(); rst_n = 1'b1;

        // lone write from port 0
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        smp(); chk("w_idle_gnt0", gnt0, 0); step();
        smp();
        chk("w_gnt0", gnt0, 1); chk("w_wen", mem_wr_en, 1);
        chk("w_addr", mem_addr, 8'h10); chk("w_din", mem_dat_in, 8'hA5); chk("w_gnt1", gnt1, 0);
        step();
        req0 = 0;
        smp(); chk("w_drop_gnt0", gnt0, 0); chk("w_drop_wen", mem_wr_en, 0); chk("w_rv0", rvalid0, 0);
        step();

        // port 1 reads back the write
        req1 = 1; we1 = 0; addr1 = 8'h10;
        smp(); chk("r_idle_gnt1", gnt1, 0); step();
        smp(); chk("r_gnt1", gnt1, 1); chk("r_wen", mem_wr_en, 0); chk("r_addr", mem_addr, 8'h10); step();
        req1 = 0;
        smp(); chk("r_rv1", rvalid1, 1); chk("r_rd1", rdata1, 8'hA5); chk("r_gnt1_off", gnt1, 0); step();
        smp(); chk("r_rv1_pulse", rvalid1, 0); chk("r_rd1_hold", rdata1, 8'hA5); step();

        // both request from reset: port 0 first, port 1 next, no bubble
        rst_n = 1'b0; smp(); chk_quiet("rst2"); step(); rst_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 8'h10; req1 = 1; we1 = 0; addr1 = 8'h11;
        smp(); chk("b_idle0", gnt0, 0); chk("b_idle1", gnt1, 0); step();
        smp(); chk("b_gnt0", gnt0, 1); chk("b_gnt1_lo", gnt1, 0); step();
        req0 = 0;
        smp();
        chk("b_gnt1", gnt1, 1); chk("b_gnt0_lo", gnt0, 0); chk("b_addr", mem_addr, 8'h11);
        chk("b_rv0", rvalid0, 1); chk("b_rd0", rdata0, 8'hA5);
        step();
        req1 = 0;
        smp(); chk("b_rv1", rvalid1, 1); chk("b_rd1", rdata1, 8'h2D); chk("b_gnt1_off", gnt1, 0); step();

        // locked port 0 gets MAX_HOLD grants, then port 1
        req0 = 1; lock0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h5A;
        req1 = 1; we1 = 0; addr1 = 8'h10;
        smp(); chk("l_idle", gnt0, 0); step();
        for (int i = 0; i < 4; i++) begin
            smp(); chk($sformatf("l_gnt0_%0d", i), gnt0, 1); chk($sformatf("l_gnt1_%0d", i), gnt1, 0);
            chk($sformatf("l_wen_%0d", i), mem_wr_en, 1);
            step();
        end
        req0 = 0; lock0 = 0;
        smp(); chk("l_gnt1", gnt1, 1); chk("l_gnt0_lo", gnt0, 0); chk("l_addr", mem_addr, 8'h10); step();
        req1 = 0;
        smp(); chk("l_rv1", rvalid1, 1); chk("l_rd1", rdata1, 8'hA5); chk("l_mem20", mem[8'h20], 8'h5A);
`ifdef ARB_STATS_EN
        chk("l_cnt0", gnt_cnt0, 5); chk("l_cnt1", gnt_cnt1, 2);
`endif
        step();

        // port 0 withdraws in its owned cycle
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'hC3;
        smp(); chk("d_idle", gnt0, 0); step();
        req0 = 0;
        smp(); chk("d_gnt0", gnt0, 0); chk("d_wen", mem_wr_en, 0); step();
        smp(); chk("d_rv0", rvalid0, 0); chk("d_mem30", mem[8'h30], 8'h0C); step();

        // reset lands in the middle of a read grant
        req1 = 1; we1 = 0; addr1 = 8'h10;
        smp(); chk("x_idle", gnt1, 0); step();
        smp(); chk("x_gnt1", gnt1, 1);
        #1 rst_n = 1'b0; req1 = 0;
        #1 chk("x_rv1_rst", rvalid1, 0); chk("x_rd1_rst", rdata1, 0);
        step(); step(); rst_n = 1'b1;
        smp(); chk_quiet("x_post");
        step();
        smp(); chk("x_rv1_late", rvalid1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
